fclass_pipe: RTL

// - Pipelined RISC-V FCLASS.S unit for the Floating ALU: reads the sign/exponent/mantissa

---
 rtl/fpu_pkg.sv | 29 ++
 rtl/fclass_pipe_if.sv | 26 ++
 rtl/fclass_decode.sv | 29 ++
 rtl/fclass_pipe.sv | 75 +++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU constants, FCLASS mask bit positions and the stage-1 flag record.
package fpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 23;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned FCLS_W = 10;

  localparam int unsigned FCLS_NINF  = 0;
  localparam int unsigned FCLS_NNORM = 1;
  localparam int unsigned FCLS_NSUB  = 2;
  localparam int unsigned FCLS_NZERO = 3;
  localparam int unsigned FCLS_PZERO = 4;
  localparam int unsigned FCLS_PSUB  = 5;
  localparam int unsigned FCLS_PNORM = 6;
  localparam int unsigned FCLS_PINF  = 7;
  localparam int unsigned FCLS_SNAN  = 8;
  localparam int unsigned FCLS_QNAN  = 9;

  typedef struct packed {
    logic sign;
    logic exp_ones;
    logic exp_zero;
    logic man_zero;
    logic man_msb;
  } fclass_flags_t;

endpackage

// File: rtl/fclass_pipe_if.sv
// Operand/result handshake bundle for the FCLASS pipeline.
interface fclass_pipe_if
  import fpu_pkg::*;
#(
  parameter int unsigned XLEN  = fpu_pkg::XLEN,
  parameter int unsigned TAG_W = fpu_pkg::TAG_W
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  rs1;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  rd;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, rs1, in_tag, out_ready,
    output in_ready, out_valid, rd, out_tag
  );

  modport master (
    output in_valid, rs1, in_tag, out_ready,
    input  in_ready, out_valid, rd, out_tag
  );
endinterface

// File: rtl/fclass_decode.sv
// Combinational FCLASS decode: field flags to a 10-bit one-hot class mask.
module fclass_decode
  import fpu_pkg::*;
(
  input  fclass_flags_t     flags,
  output logic [FCLS_W-1:0] mask
);

  always_comb begin
    mask = '0;
    if (flags.exp_ones) begin
      // NaN classes deliberately ignore the sign bit
      if (flags.man_zero)
        mask[flags.sign ? FCLS_NINF : FCLS_PINF] = 1'b1;
      else if (flags.man_msb)
        mask[FCLS_QNAN] = 1'b1;
      else
        mask[FCLS_SNAN] = 1'b1;
    end else if (flags.exp_zero) begin
      if (flags.man_zero)
        mask[flags.sign ? FCLS_NZERO : FCLS_PZERO] = 1'b1;
      else
        mask[flags.sign ? FCLS_NSUB : FCLS_PSUB] = 1'b1;
    end else begin
      mask[flags.sign ? FCLS_NNORM : FCLS_PNORM] = 1'b1;
    end
  end

endmodule

// File: rtl/fclass_pipe.sv
// Two-stage FCLASS.S pipeline: stage 1 captures field flags, stage 2 holds the mask.
module fclass_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned XLEN  = fpu_pkg::XLEN,
  parameter int unsigned EXP_W = fpu_pkg::EXP_W,
  parameter int unsigned MAN_W = fpu_pkg::MAN_W,
  parameter int unsigned TAG_W = fpu_pkg::TAG_W
)(
  input  logic         clk,
  input  logic         rst,
  fclass_pipe_if.slave bus
);

  logic             s1_valid;
  fclass_flags_t    s1_flags;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid;
  logic             adv1;
  logic             adv2;
  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  fclass_flags_t    in_flags;
  logic [FCLS_W-1:0] mask;

  assign exp_f = bus.rs1[XLEN-2 -: EXP_W];
  assign man_f = bus.rs1[MAN_W-1:0];

  always_comb begin
    in_flags          = '0;
    in_flags.sign     = bus.rs1[XLEN-1];
    in_flags.exp_ones = &exp_f;
    in_flags.exp_zero = ~|exp_f;
    in_flags.man_zero = ~|man_f;
    in_flags.man_msb  = man_f[MAN_W-1];
  end

  // Backpressure ripples combinationally from out_ready so a full pipe still streams.
  assign adv2         = !s2_valid || bus.out_ready;
  assign adv1         = !s1_valid || adv2;
  assign bus.in_ready = adv1;
  assign bus.out_valid = s2_valid;

  fclass_decode u_decode (
    .flags (s1_flags),
    .mask  (mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_flags    <= '0;
      s1_tag      <= '0;
      s2_valid    <= 1'b0;
      bus.rd      <= '0;
      bus.out_tag <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_flags <= in_flags;
          s1_tag   <= bus.in_tag;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          bus.rd      <= XLEN'(mask);
          bus.out_tag <= s1_tag;
        end
      end
    end
  end

endmodule
